// File: rtl/palram_pkg.sv
// Shared types and default widths for the palette RAM arbiter.
package palram_pkg;

    localparam int unsigned PALRAM_ADDR_W     = 8;
    localparam int unsigned PALRAM_DATA_W     = 8;
    localparam int unsigned PALRAM_FIFO_DEPTH = 4;

    typedef enum logic {PR_INIT, PR_RUN} palram_state_t;

    typedef struct packed {
        logic [PALRAM_ADDR_W-1:0] addr;
        logic [PALRAM_DATA_W-1:0] data;
    } palram_wr_t;

endpackage

// File: rtl/palram_wr_fifo.sv
// Synchronous FIFO buffering CPU palette writes until the RAM port is free.
module palram_wr_fifo
    import palram_pkg::*;
#(
    parameter int unsigned DEPTH   = PALRAM_FIFO_DEPTH,
    parameter type         entry_t = palram_wr_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/palette_ram_arbiter.sv
// Arbitrates a single-port palette RAM between video reads and buffered CPU writes.
// Define PALRAM_BLANK_ONLY_EN to drain CPU writes only while cmpblk2 (blanking) is high.
module palette_ram_arbiter
    import palram_pkg::*;
#(
    parameter int unsigned ADDR_W     = PALRAM_ADDR_W,
    parameter int unsigned DATA_W     = PALRAM_DATA_W,
    parameter int unsigned FIFO_DEPTH = PALRAM_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vid_req,
    input  logic [ADDR_W-1:0]             vid_addr,
    output logic [DATA_W-1:0]             vid_data,
    output logic                          vid_valid,
    input  logic                          cmpblk2,
    input  logic                          cpu_wr_valid,
    output logic                          cpu_wr_ready,
    input  logic [ADDR_W-1:0]             cpu_wr_addr,
    input  logic [DATA_W-1:0]             cpu_wr_data,
    output logic                          init_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_din,
    input  logic [DATA_W-1:0]             ram_dout
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    palram_state_t     state_q;
    logic [ADDR_W-1:0] sweep_addr_q;
    logic              vid_valid_q;

    logic              wr_gate;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    wr_entry_t         fifo_in;
    wr_entry_t         fifo_head;

`ifdef PALRAM_BLANK_ONLY_EN
    assign wr_gate = cmpblk2;
`else
    logic unused_cmpblk2;
    assign unused_cmpblk2 = cmpblk2;
    assign wr_gate        = 1'b1;
`endif

    assign init_done    = (state_q == PR_RUN);
    assign cpu_wr_ready = (state_q == PR_RUN) & ~fifo_full;
    assign fifo_push    = cpu_wr_valid & cpu_wr_ready;
    assign fifo_pop     = (state_q == PR_RUN) & ~vid_req & ~fifo_empty & wr_gate;
    assign fifo_in      = '{addr: cpu_wr_addr, data: cpu_wr_data};

    assign vid_valid = vid_valid_q;
    assign vid_data  = vid_valid_q ? ram_dout : '0;

    palram_wr_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (wr_entry_t)
    ) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PR_INIT;
            sweep_addr_q <= '0;
            vid_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                PR_INIT: begin
                    vid_valid_q  <= 1'b0;
                    sweep_addr_q <= sweep_addr_q + 1'b1;
                    if (&sweep_addr_q) state_q <= PR_RUN;
                end
                PR_RUN: begin
                    vid_valid_q <= vid_req;
                end
                default: begin
                    state_q     <= PR_INIT;
                    vid_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state_q)
            PR_INIT: begin
                // Held idle while in reset so the first sweep write lands on the first edge after release.
                ram_en   = rst_n;
                ram_we   = rst_n;
                ram_addr = sweep_addr_q;
            end
            PR_RUN: begin
                if (vid_req) begin
                    ram_en   = 1'b1;
                    ram_addr = vid_addr;
                end else if (fifo_pop) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = fifo_head.addr;
                    ram_din  = fifo_head.data;
                end
            end
            default: ;
        endcase
    end

endmodule
